seq_frame_scanner: RTL and testbench
====================================

Name: seq_frame_scanner

Overview:
- Byte-stream front end and controller for a serial "1011" Moore pattern detector, which is instantiated inside this block.
- Accepts bytes over a valid/ready handshake and serializes each byte MSB-first into the detector, one bit per clock.
- Clears the detector at each frame start and counts detections per frame, supporting overlapping and non-overlapping modes.
- Reports the saturated match count with a one-cycle done pulse at frame end.

Parameters:
CNT_W, 8, width of match_count; count saturates at 2^CNT_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  byte available on in_data
in_data  input  8  byte to scan, bit 7 shifted first
in_last  input  1  qualifies in_valid: this byte ends the frame
in_ready  output  1  block can accept a byte this cycle
ovl_mode  input  1  1 = overlapping detection, 0 = non-overlapping; sampled at frame-start accept, held for the frame
match_pulse  output  1  one-cycle pulse per detection
match_count  output  CNT_W  detections in current/last frame
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse, match_count final

Behaviour:
- Reset: state=IDLE, detector=S0, match_count=0, match_pulse=0, done=0, busy=0, in_ready=1 (combinational from IDLE).
- Handshake: transfer occurs when in_valid && in_ready. in_data/in_last are ignored otherwise.
- Controller states: IDLE, SHIFT, WAIT, FLUSH, DONE.
- IDLE:
  - in_ready=1.
  - On transfer: load the shift register, clear the bit index to 0, force the detector to S0, clear match_count to 0, latch ovl_mode and in_last, then go to SHIFT.
- SHIFT:
  - Each cycle applies shreg[7-idx] to the detector at the clock edge, and idx increments.
  - in_ready=1 only when idx==7 and the latched last flag is 0.
  - At idx==7:
    - latched last=1 -> FLUSH;
    - transfer -> reload, idx=0, stay in SHIFT (back-to-back, 8 cycles/byte, no bubble);
    - no transfer -> WAIT.
- WAIT:
  - in_ready=1 and the detector holds.
  - On transfer: reload and go to SHIFT.
  - The detector is NOT cleared, so patterns span byte boundaries within a frame.
- FLUSH: one cycle, no bit applied; captures a detection caused by the final bit. Then go to DONE.
- DONE: done=1 for exactly one cycle, in_ready=0, then go to IDLE.
- match_count holds its final value until the next frame-start accept.
- Detector (3-bit Moore): S0 none, S1 "1", S2 "10", S3 "101", S4 "1011".
  - S0: x=1->S1, x=0->S0.
  - S1: 1->S1, 0->S2.
  - S2: 1->S3, 0->S0.
  - S3: 1->S4, 0->S2.
  - S4, overlapping: 1->S1, 0->S2.
  - S4, non-overlapping: 1->S1, 0->S0.
  - The detector updates only on bit-apply edges and holds otherwise.
- Detection event: registered flag bit_applied (set at any edge that applied a bit).
  - Event = (det_state==S4) && bit_applied.
  - match_pulse = event, combinational from registers.
  - Latency: high in the cycle immediately after the edge that applied the 4th pattern bit.
  - match_count increments at the edge ending an event cycle. A stall in WAIT never double-counts.
- Saturation: match_count stops at 2^CNT_W-1 and never wraps.
- Frame end: the event from the last bit of the frame occurs in the FLUSH cycle, so it is counted before done.
- Reset mid-frame: returns to IDLE immediately and discards the partial frame. No done pulse is generated.
- No cross-frame detection: the detector is cleared at every frame-start accept.

Test Plan:
- Single byte 0xB0, in_last=1, ovl=1 -> match_pulse once, in the cycle after the 4th bit edge (5th cycle after accept); done 10 cycles after accept; match_count=1.
- Byte 0xB6 (10110110), last, ovl=1 -> 2 pulses, count=2. Same byte with ovl=0 -> count=1.
- Bytes 0x01 then 0x60 (last), back-to-back -> in_ready=1 on idx==7 of the first byte, no bubble; the pattern spanning the boundary gives count=1.
- Same as the previous test but in_valid dropped for 5 cycles between bytes -> WAIT holds the detector, count=1, no extra pulse.
- CNT_W=2, four 0xBB bytes (last on 4th) -> 8 detections, match_count saturates at 3.
- rst asserted during the 2nd byte of a frame -> next cycle IDLE, count=0, in_ready=1, no done pulse. A following 0xB0 frame gives count=1.

Source files
------------

// File: rtl/seq_frame_scanner.sv
// seq_frame_scanner
//   Byte-stream front end for a serial "1011" Moore pattern detector.
//   Bytes arrive over a valid/ready handshake and are shifted MSB-first
//   into the detector, one bit per clock. The detector is cleared at each
//   frame start, detections are counted per frame (saturating), and a
//   one-cycle done pulse marks the final count.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_valid     - byte available on in_data
//   in_data      - byte to scan, bit 7 first
//   in_last      - this byte ends the frame (qualified by in_valid)
//   in_ready     - block accepts a byte this cycle
//   ovl_mode     - 1 overlapping / 0 non-overlapping, latched at frame start
//   match_pulse  - one-cycle pulse per detection
//   match_count  - detections in current/last frame, saturating
//   busy         - frame in progress
//   done         - one-cycle pulse, match_count final
module seq_frame_scanner #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             ovl_mode,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_FLUSH,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4
    } det_t;

    state_t     state, state_n;
    det_t       det, det_n;
    logic [7:0] shreg;
    logic [2:0] idx;
    logic       last_l;
    logic       ovl_l;
    logic       bit_applied;
    logic       load;
    logic       apply;
    logic       frame_start;
    logic       bit_in;
    logic       det_event;

    assign bit_in      = shreg[3'd7 - idx];
    assign frame_start = (state == ST_IDLE) && in_valid;
    // Detection is visible only in the cycle right after the bit that
    // reached S4, so holding in WAIT cannot count the same match twice.
    assign det_event   = (det == S4) && bit_applied;
    assign match_pulse = det_event;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        load     = 1'b0;
        apply    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                apply = 1'b1;
                if (idx == 3'd7) begin
                    if (last_l) begin
                        state_n = ST_FLUSH;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) load = 1'b1;
                        else          state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_FLUSH: state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        det_n = S0;
        case (det)
            S0:      det_n = bit_in ? S1 : S0;
            S1:      det_n = bit_in ? S1 : S2;
            S2:      det_n = bit_in ? S3 : S0;
            S3:      det_n = bit_in ? S4 : S2;
            S4:      det_n = bit_in ? S1 : (ovl_l ? S2 : S0);
            default: det_n = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            det         <= S0;
            shreg       <= '0;
            idx         <= '0;
            last_l      <= 1'b0;
            ovl_l       <= 1'b0;
            bit_applied <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_n;
            bit_applied <= apply;

            // A reload at idx==7 also applies the old byte's last bit;
            // the index restart takes priority over the increment.
            if (load) begin
                shreg  <= in_data;
                idx    <= '0;
                last_l <= in_last;
            end else if (apply) begin
                idx <= idx + 3'd1;
            end

            if (frame_start) begin
                ovl_l       <= ovl_mode;
                det         <= S0;
                match_count <= '0;
            end else begin
                if (apply) det <= det_n;
                if (det_event && (match_count != '1))
                    match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_frame_scanner.sv
// Scoreboard bench for seq_frame_scanner: two instances (CNT_W=8 and
// CNT_W=2) share stimulus; the driver pushes hand-computed frame results
// and a negedge monitor checks them at each done pulse.
module tb_seq_frame_scanner;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       ovl_mode;

    logic       in_ready8, match_pulse8, busy8, done8;
    logic [7:0] match_count8;
    logic       in_ready2, match_pulse2, busy2, done2;
    logic [1:0] match_count2;

    int cyc;
    int n_chk;
    int n_fail;

    typedef struct {
        int exp_cnt;
        int last_acc;
        int first_acc;
        int first_lat;
    } exp_t;

    exp_t q[$];

    seq_frame_scanner #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready8), .ovl_mode(ovl_mode),
        .match_pulse(match_pulse8), .match_count(match_count8),
        .busy(busy8), .done(done8)
    );

    seq_frame_scanner #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready2), .ovl_mode(ovl_mode),
        .match_pulse(match_pulse2), .match_count(match_count2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts pulses and checks each done against the scoreboard.
    int pulses = 0;
    int first_pulse = -1;
    always @(negedge clk) begin
        if (rst) begin
            pulses      = 0;
            first_pulse = -1;
        end else begin
            if (match_pulse8 || match_pulse2) begin
                check("pulse_w2_vs_w8", int'(match_pulse2), int'(match_pulse8));
                pulses++;
                if (first_pulse < 0) first_pulse = cyc;
            end
            if (done8 || done2) begin
                if (q.size() == 0) begin
                    check("unexpected_done", int'(done8 | done2), 0);
                end else begin
                    exp_t e;
                    int c2;
                    e  = q.pop_front();
                    c2 = (e.exp_cnt > 3) ? 3 : e.exp_cnt;
                    check("count_w8", int'(match_count8), e.exp_cnt);
                    check("count_w2_sat", int'(match_count2), c2);
                    check("pulse_total", pulses, e.exp_cnt);
                    check("done_latency", cyc - e.last_acc, 9);
                    check("done_w2", int'(done2), 1);
                    check("busy_in_done", int'(busy8), 1);
                    check("ready_in_done", int'(in_ready8), 0);
                    if (e.first_lat >= 0)
                        check("first_pulse_latency", first_pulse - e.first_acc, e.first_lat);
                end
                pulses      = 0;
                first_pulse = -1;
            end
        end
    end

    // Entered and left at #1 after a posedge.
    task automatic send_byte(input logic [7:0] d, input logic l, input int gap,
                             output int acc);
        int t;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        t = 0;
        acc = -1;
        forever begin
            @(negedge clk);
            if (in_ready8) break;
            t++;
            if (t > 200) begin
                check("ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input int n, input logic ovl, input int gap,
                             input int exp_cnt, input int first_lat);
        logic [7:0] bs[4];
        exp_t e;
        int acc, prev, t;
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        ovl_mode = ovl;
        prev = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(bs[i], (i == n - 1), (i == 0) ? 0 : gap, acc);
            if (i == 0) begin
                e.first_acc = acc;
                ovl_mode = ~ovl;   // must be ignored for the rest of the frame
            end
            if (i > 0 && gap == 0) check("b2b_spacing", acc - prev, 8);
            prev = acc;
        end
        e.exp_cnt   = exp_cnt;
        e.last_acc  = acc;
        e.first_lat = first_lat;
        q.push_back(e);
        t = 0;
        while (q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 0, 1);
            q.delete();
        end
        repeat (3) @(negedge clk);
        check("count_hold", int'(match_count8), exp_cnt);
        check("idle_after_frame", int'(busy8), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        ovl_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(in_ready8), 1);
        check("rst_busy", int'(busy8), 0);
        check("rst_count", int'(match_count8), 0);
        check("rst_pulse", int'(match_pulse8), 0);
        check("rst_done", int'(done8), 0);
        check("rst_count_w2", int'(match_count2), 0);
        @(posedge clk);
        #1;

        run_frame(8'hB0, 8'h00, 8'h00, 8'h00, 1, 1'b1, 0, 1, 4);
        run_frame(8'hB6, 8'h00, 8'h00, 8'h00, 1, 1'b1, 0, 2, -1);
        run_frame(8'hB6, 8'h00, 8'h00, 8'h00, 1, 1'b0, 0, 1, -1);
        run_frame(8'h01, 8'h60, 8'h00, 8'h00, 2, 1'b1, 0, 1, -1);
        run_frame(8'h01, 8'h60, 8'h00, 8'h00, 2, 1'b1, 13, 1, -1);
        run_frame(8'hBB, 8'hBB, 8'hBB, 8'hBB, 4, 1'b1, 0, 8, -1);

        // Reset in the middle of the second byte: no done may follow.
        ovl_mode = 1'b1;
        send_byte(8'hB0, 1'b0, 0, acc);
        send_byte(8'hBB, 1'b0, 0, acc);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy8), 0);
        check("midrst_ready", int'(in_ready8), 1);
        check("midrst_count", int'(match_count8), 0);
        check("midrst_done", int'(done8), 0);
        repeat (15) @(negedge clk);
        check("midrst_still_idle", int'(busy8), 0);
        @(posedge clk);
        #1;
        run_frame(8'hB0, 8'h00, 8'h00, 8'h00, 1, 1'b1, 0, 1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
